// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the sequential 12-bit to mini-float converter.
package fpcvt_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  // Upper bound on normalisation shifts; also the exponent bias reference
  localparam logic [EXP_W-1:0] MAX_SHIFT = 3'd7;

endpackage

// File: rtl/twos_to_sm.sv
// Combinational two's-complement to sign/magnitude converter.
// The most negative input (0x800) maps to magnitude 0x800 (2048).
module twos_to_sm
  import fpcvt_pkg::*;
(
  input  logic [IN_W-1:0] d,
  output logic            sign,
  output logic [IN_W-1:0] mag
);

  // Negate negative samples; the 12-bit wrap of -0x800 yields 0x800 as required
  always_comb begin
    sign = d[IN_W-1];
    mag  = d;
    if (d[IN_W-1]) begin
      mag = (~d) + 12'd1;
    end
  end

endmodule

// File: rtl/fpcvt_seq.sv
// Sequential converter: accepts a 12-bit two's-complement sample, normalises it
// one bit per cycle and rounds it into a 1/3/4-bit sign/exponent/significand value.
module fpcvt_seq
  import fpcvt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             S,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t            state;
  state_t            state_next;
  logic [IN_W-1:0]   mag;
  logic [IN_W-1:0]   mag_next;
  logic [EXP_W-1:0]  cnt;
  logic [EXP_W-1:0]  cnt_next;
  logic              sign;
  logic              sign_next;
  logic              s_next;
  logic [EXP_W-1:0]  e_next;
  logic [SIG_W-1:0]  f_next;

  logic              sm_sign;
  logic [IN_W-1:0]   sm_mag;

  logic [EXP_W-1:0]  exp_raw;
  logic [SIG_W-1:0]  sig_raw;
  logic [EXP_W-1:0]  rnd_exp;
  logic [SIG_W-1:0]  rnd_sig;

  twos_to_sm u_twos_to_sm (
    .d    (D),
    .sign (sm_sign),
    .mag  (sm_mag)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Rounder: exponent from shift count, four significand bits below the leading one
  always_comb begin
    exp_raw = MAX_SHIFT - cnt;
    sig_raw = mag[10:7];
    rnd_exp = exp_raw;
    rnd_sig = sig_raw;
    if (mag[11]) begin
      rnd_exp = 3'd7;
      rnd_sig = 4'hF;
    end else if (mag[6]) begin
      if (sig_raw != 4'hF) begin
        rnd_sig = sig_raw + 4'd1;
      end else if (exp_raw != 3'd7) begin
        rnd_sig = 4'b1000;
        rnd_exp = exp_raw + 3'd1;
      end else begin
        rnd_exp = 3'd7;
        rnd_sig = 4'hF;
      end
    end
  end

  // Next-state and datapath update for the accept/normalise/round/handshake sequence
  always_comb begin
    state_next = state;
    mag_next   = mag;
    cnt_next   = cnt;
    sign_next  = sign;
    s_next     = S;
    e_next     = E;
    f_next     = F;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_next  = sm_sign;
          mag_next   = sm_mag;
          cnt_next   = '0;
          state_next = NORM;
        end
      end
      NORM: begin
        if (mag[11] || mag[10] || (cnt == MAX_SHIFT)) begin
          state_next = ROUND;
        end else begin
          mag_next = {mag[IN_W-2:0], 1'b0};
          cnt_next = cnt + 3'd1;
        end
      end
      ROUND: begin
        s_next     = sign;
        e_next     = rnd_exp;
        f_next     = rnd_sig;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any sample in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      S     <= 1'b0;
      E     <= '0;
      F     <= '0;
    end else begin
      state <= state_next;
      mag   <= mag_next;
      cnt   <= cnt_next;
      sign  <= sign_next;
      S     <= s_next;
      E     <= e_next;
      F     <= f_next;
    end
  end

endmodule

// File: doc/fpcvt_seq.md
FPCVT_SEQ -- requirements
Module: fpcvt_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed: 12-bit input, 1/3/4-bit sign/exponent/significand output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 D  input  12  two's-complement sample.
REQ-005 in_valid  input  1  D is valid.
REQ-006 in_ready  output  1  block can accept; high only in IDLE.
REQ-007 S  output  1  sign of the result.
REQ-008 E  output  3  exponent.
REQ-009 F  output  4  significand.
REQ-010 out_valid  output  1  S/E/F valid; high only in DONE.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high in NORM, ROUND and DONE.

Function
REQ-013 States: IDLE, NORM, ROUND, DONE.
REQ-014 IDLE: on in_valid && in_ready, register sign = D[11] and mag = twos_to_sm(D); clear cnt (3-bit); go to NORM. Otherwise hold.
REQ-015 NORM: if mag[11]==1, or mag[10]==1, or cnt==7, go to ROUND. Otherwise shift mag left 1 (zero fill), increment cnt, stay.
REQ-016 ROUND, when mag[11]==1 (magnitude 2048): result E=7, F=1111.
REQ-017 ROUND, otherwise:
- E = 7 - cnt
- F = mag[10:7]
- round bit = mag[6]
- if round bit==1 and F!=1111: F = F+1
- if round bit==1, F==1111 and E<7: F=1000, E=E+1
- if round bit==1, F==1111 and E==7: saturate to E=7, F=1111
REQ-018 ROUND: register S = sign and the E/F result, then go to DONE.
REQ-019 DONE: out_valid=1; S/E/F stable; in_ready=0; on out_ready go to IDLE. out_valid deasserts the next cycle.
REQ-020 Latency: out_valid asserts n+2 cycles after the accept edge, where n = shifts performed (0..7); maximum 9 cycles.
REQ-021 Zero input yields S=0, E=0, F=0000 after 7 shifts.
REQ-022 New input is never accepted while busy; in_valid outside IDLE is ignored.
REQ-023 S/E/F hold their last result in IDLE until the next ROUND.

Reset
REQ-024 rst is sampled on clk, overrides all state, and returns to IDLE from any state, including mid-NORM; any in-flight sample is discarded.
REQ-025 Outputs after reset: S=0, E=0, F=0, out_valid=0, busy=0, in_ready=1; mag, cnt and sign are cleared.

Structure
REQ-026 Shared package fpcvt_pkg SHALL hold:
- state enumeration (IDLE/NORM/ROUND/DONE)
- width constants IN_W=12, EXP_W=3, SIG_W=4
- constant MAX_SHIFT=7
REQ-027 SHALL instantiate the existing twos_to_sm converter combinationally on D as its single sub-module; the FSM, shifter, counter and rounder are local.

Verification
REQ-028 D=0x07D, then in_valid pulse -> 4 shifts; S=0, E=4, F=1000 (rounding overflow); out_valid 6 cycles after accept.
REQ-029 D=0x800 -> S=1, E=7, F=1111; out_valid 2 cycles after accept.
REQ-030 D=0x7FF -> S=0, E=7, F=1111 (saturation at E=7); D=0xFFF -> S=1, E=0, F=0001, 9 cycles.
REQ-031 D=0x000 -> S=0, E=0, F=0000; hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored.
REQ-032 Assert rst during NORM (D=0x001) -> next cycle IDLE, in_ready=1, out_valid=0, all outputs zero; a following D=0x07D converts correctly.
